// File: rtl/control_sequencer.sv
// Microcode sequencer for the 8-bit bus computer: step counter, halt latch and control-word decode.
// Build option EARLY_RESET_EN: restart at step 0 after each opcode's last non-empty microstep.
module control_sequencer #(
    parameter int N      = 8,
    parameter int STEPS  = 5,
    parameter int STEP_W = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [N-1:0]      ir,
    input  logic              cf,
    input  logic              zf,
    input  logic              prog,
    output logic              hlt,
    output logic              mi,
    output logic              ri,
    output logic              ro,
    output logic              io,
    output logic              ii,
    output logic              ai,
    output logic              ao,
    output logic              eo,
    output logic              su,
    output logic              bi,
    output logic              oi,
    output logic              ce,
    output logic              co,
    output logic              j,
    output logic              fi,
    output logic [STEP_W-1:0] step,
    output logic              halted
);

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    typedef struct packed {
        logic hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi;
    } ctrl_t;

    logic [3:0]        opcode;
    logic              ir_unused;
    ctrl_t             ucode;
    ctrl_t             ctrl;
    logic [STEP_W-1:0] last_step;
    logic [STEP_W-1:0] step_nxt;
    logic              halted_nxt;

    assign opcode    = ir[N-1:N-4];
    assign ir_unused = ^ir[N-5:0];

    // Raw microcode: fetch in steps 0/1, opcode-specific execute in steps 2..4.
    always_comb begin
        ucode = '0;
        case (step)
            STEP_W'(0): begin
                ucode.mi = 1'b1;
                ucode.co = 1'b1;
            end
            STEP_W'(1): begin
                ucode.ro = 1'b1;
                ucode.ii = 1'b1;
                ucode.ce = 1'b1;
            end
            STEP_W'(2): begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ucode.io = 1'b1;
                        ucode.mi = 1'b1;
                    end
                    OP_LDI: begin
                        ucode.io = 1'b1;
                        ucode.ai = 1'b1;
                    end
                    OP_JMP: begin
                        ucode.io = 1'b1;
                        ucode.j  = 1'b1;
                    end
                    OP_JC: begin
                        ucode.io = cf;
                        ucode.j  = cf;
                    end
                    OP_JZ: begin
                        ucode.io = zf;
                        ucode.j  = zf;
                    end
                    OP_OUT: begin
                        ucode.ao = 1'b1;
                        ucode.oi = 1'b1;
                    end
                    OP_HLT:  ucode.hlt = 1'b1;
                    default: ;
                endcase
            end
            STEP_W'(3): begin
                case (opcode)
                    OP_LDA: begin
                        ucode.ro = 1'b1;
                        ucode.ai = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ucode.ro = 1'b1;
                        ucode.bi = 1'b1;
                    end
                    OP_STA: begin
                        ucode.ao = 1'b1;
                        ucode.ri = 1'b1;
                    end
                    default: ;
                endcase
            end
            STEP_W'(4): begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    ucode.eo = 1'b1;
                    ucode.ai = 1'b1;
                    ucode.fi = 1'b1;
                    ucode.su = (opcode == OP_SUB);
                end
            end
            default: ;
        endcase
    end

`ifdef EARLY_RESET_EN
    always_comb begin
        int unsigned last;
        case (opcode)
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT: last = 2;
            OP_LDA, OP_STA:                       last = 3;
            OP_ADD, OP_SUB:                       last = 4;
            OP_HLT:                               last = STEPS - 1;
            default:                              last = 1;
        endcase
        if (last > STEPS - 1)
            last = STEPS - 1;
        last_step = STEP_W'(last);
    end
`else
    assign last_step = STEP_W'(STEPS - 1);
`endif

    always_ff @(posedge clk) begin
        step   <= step_nxt;
        halted <= halted_nxt;
    end

    // Priority: clr, then manual mode, then the halt latch, then normal sequencing.
    always_comb begin
        step_nxt   = step;
        halted_nxt = halted;
        if (clr) begin
            step_nxt   = '0;
            halted_nxt = 1'b0;
        end else if (!prog) begin
            step_nxt = '0;
        end else if (halted) begin
            step_nxt = step;
        end else if (ucode.hlt) begin
            halted_nxt = 1'b1;
        end else if (step == last_step) begin
            step_nxt = '0;
        end else begin
            step_nxt = step + STEP_W'(1);
        end
    end

    always_comb begin
        ctrl = ucode;
        if (clr || !prog) begin
            ctrl = '0;
        end else if (halted) begin
            ctrl     = '0;
            ctrl.hlt = 1'b1;
        end
    end

    assign {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi} = ctrl;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: expected step/control/halt values queued per cycle,
// popped and compared on the falling edge.
module tb_control_sequencer;

    localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000,
                            IO  = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100,
                            EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010,
                            CE  = 16'h0008, CO = 16'h0004, J  = 16'h0002, FI = 16'h0001;

    logic       clk, clr, cf, zf, prog;
    logic [7:0] ir;
    logic       hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi;
    logic [2:0] step;
    logic       halted;
    logic [15:0] cw;
    logic [4:0]  drivers;

    typedef struct packed {
        logic [2:0]  st;
        logic [15:0] cw;
        logic        h;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    errors = 0;
    int    checks = 0;

    control_sequencer #(.N(8), .STEPS(5), .STEP_W(3)) dut (
        .clk(clk), .clr(clr), .ir(ir), .cf(cf), .zf(zf), .prog(prog),
        .hlt(hlt), .mi(mi), .ri(ri), .ro(ro), .io(io), .ii(ii), .ai(ai), .ao(ao),
        .eo(eo), .su(su), .bi(bi), .oi(oi), .ce(ce), .co(co), .j(j), .fi(fi),
        .step(step), .halted(halted)
    );

    assign cw      = {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi};
    assign drivers = {ro, io, ao, eo, co};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    // Queue the expectation for the current cycle, compare at the falling edge, advance one cycle.
    task automatic chk(input string tag, input int unsigned st, input logic [15:0] ew, input logic eh);
        exp_t  e;
        string t;
        exp_q.push_back('{st: 3'(st), cw: ew, h: eh});
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (cw === e.cw) else begin
            errors++;
            $error("FAIL %s ctrl observed=%h expected=%h", t, cw, e.cw);
        end
        checks++;
        assert (step === e.st) else begin
            errors++;
            $error("FAIL %s step observed=%0d expected=%0d", t, step, e.st);
        end
        checks++;
        assert (halted === e.h) else begin
            errors++;
            $error("FAIL %s halted observed=%b expected=%b", t, halted, e.h);
        end
        checks++;
        assert ($countones(drivers) <= 1) else begin
            errors++;
            $error("FAIL %s bus drivers observed=%b expected at most one", t, drivers);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag);
        chk({tag, "_s0"}, 0, MI | CO, 1'b0);
        chk({tag, "_s1"}, 1, RO | II | CE, 1'b0);
    endtask

    // Empty trailing steps only exist in the fixed-period build.
    task automatic tail(input string tag, input int unsigned last);
`ifndef EARLY_RESET_EN
        for (int unsigned s = last + 1; s < 5; s++)
            chk({tag, "_tail"}, s, 16'h0000, 1'b0);
`endif
    endtask

    initial begin
        clr = 1'b1; prog = 1'b1; ir = 8'h00; cf = 1'b0; zf = 1'b0;
        @(posedge clk);
        #1;
        chk("reset0", 0, 16'h0000, 1'b0);
        chk("reset1", 0, 16'h0000, 1'b0);
        clr = 1'b0;

        fetch("nop");
        tail("nop", 1);

        ir = 8'h2E;
        fetch("add");
        chk("add_s2", 2, IO | MI, 1'b0);
        chk("add_s3", 3, RO | BI, 1'b0);
        chk("add_s4", 4, EO | AI | FI, 1'b0);

        ir = 8'h3E;
        fetch("sub");
        chk("sub_s2", 2, IO | MI, 1'b0);
        chk("sub_s3", 3, RO | BI, 1'b0);
        chk("sub_s4", 4, EO | AI | FI | SU, 1'b0);

        ir = 8'h7A; cf = 1'b0;
        fetch("jc_nt");
        chk("jc_nt_s2", 2, 16'h0000, 1'b0);
        tail("jc_nt", 2);
        cf = 1'b1;
        fetch("jc_t");
        chk("jc_t_s2", 2, IO | J, 1'b0);
        tail("jc_t", 2);

        ir = 8'h8A; zf = 1'b0; cf = 1'b1;
        fetch("jz_nt");
        chk("jz_nt_s2", 2, 16'h0000, 1'b0);
        tail("jz_nt", 2);
        zf = 1'b1; cf = 1'b0;
        fetch("jz_t");
        chk("jz_t_s2", 2, IO | J, 1'b0);
        tail("jz_t", 2);
        zf = 1'b0;

        ir = 8'h50;
        fetch("ldi");
        chk("ldi_s2", 2, IO | AI, 1'b0);
        tail("ldi", 2);

        ir = 8'h40;
        fetch("sta");
        chk("sta_s2", 2, IO | MI, 1'b0);
        chk("sta_s3", 3, AO | RI, 1'b0);
        tail("sta", 3);

        ir = 8'hE0;
        fetch("out");
        chk("out_s2", 2, AO | OI, 1'b0);
        tail("out", 2);

        ir = 8'hB0;
        fetch("undef");
        tail("undef", 1);

        ir = 8'hF0;
        fetch("hlt");
        chk("hlt_s2", 2, HLT, 1'b0);
        for (int i = 0; i < 10; i++)
            chk("halted", 2, HLT, 1'b1);
        ir = 8'h10;
        chk("halted_ir", 2, HLT, 1'b1);
        chk("halted_ir2", 2, HLT, 1'b1);
        clr = 1'b1;
        chk("halt_clr", 2, 16'h0000, 1'b1);
        clr = 1'b0;
        fetch("post_clr");
        chk("lda_s2", 2, IO | MI, 1'b0);
        chk("lda_s3", 3, RO | AI, 1'b0);
        tail("lda", 3);

        fetch("lda2");
        prog = 1'b0;
        chk("man_mid", 2, 16'h0000, 1'b0);
        for (int i = 0; i < 5; i++)
            chk("manual", 0, 16'h0000, 1'b0);
        prog = 1'b1;
        fetch("resume");
        chk("resume_s2", 2, IO | MI, 1'b0);
        prog = 1'b0; clr = 1'b1;
        chk("clr_prog0", 3, 16'h0000, 1'b0);
        chk("clr_prog0b", 0, 16'h0000, 1'b0);
        clr = 1'b0; prog = 1'b1;

        ir = 8'hF0;
        fetch("hlt_p0");
        prog = 1'b0;
        chk("hlt_prog0", 2, 16'h0000, 1'b0);
        chk("hlt_prog0b", 0, 16'h0000, 1'b0);
        prog = 1'b1;
        fetch("hlt_again");
        chk("hlt_again_s2", 2, HLT, 1'b0);
        chk("hlt_again_h", 2, HLT, 1'b1);
        prog = 1'b0;
        chk("halt_man", 2, 16'h0000, 1'b1);
        chk("halt_man_held", 0, 16'h0000, 1'b1);
        prog = 1'b1;
        chk("halt_resume", 0, HLT, 1'b1);
        chk("halt_frozen", 0, HLT, 1'b1);
        clr = 1'b1;
        chk("halt_clr2", 0, 16'h0000, 1'b1);
        clr = 1'b0;
        chk("final_s0", 0, MI | CO, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
